// File: rtl/playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : playback_sequencer
// Description : Reads recorded note entries from a buffer and sounds each one
//               for NOTE_CYCLES clocks, prefetching the next entry so that
//               consecutive entries play back without a gap.
// Revision    : 1.0 - initial release
// ============================================================================
module playback_sequencer #(
    parameter int NOTE_CYCLES = 250000,
    parameter int CNT_W       = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] rec_len,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [5:0] rd_data,
    output logic [2:0] octave,
    output logic [2:0] note,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(NOTE_CYCLES - 1);
    // Read issued so that its data arrives on the final hold cycle.
    localparam logic [CNT_W-1:0] PREFETCH_CNT = CNT_W'(NOTE_CYCLES - 3);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       idx;
    logic [7:0]       len;
    logic             start_q;
    logic             start_armed;
    logic             start_edge;
    logic             last_entry;

    // After reset the start line must be seen low before an edge counts.
    assign start_edge = start & ~start_q & start_armed;
    assign last_entry = (idx == 8'(len - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            len         <= '0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            octave      <= '0;
            note        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_q <= start;
            if (!start) begin
                start_armed <= 1'b1;
            end
            rd_en <= 1'b0;
            done  <= 1'b0;

            if (state == IDLE) begin
                if (start_edge && !stop) begin
                    if (rec_len == 8'd0) begin
                        done <= 1'b1;
                    end else begin
                        len     <= rec_len;
                        idx     <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= FETCH;
                    end
                end
            end else if (stop) begin
                octave <= '0;
                note   <= '0;
                busy   <= 1'b0;
                cnt    <= '0;
                state  <= IDLE;
            end else begin
                case (state)
                    FETCH: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        {octave, note} <= rd_data;
                        cnt            <= '0;
                        state          <= HOLD;
                    end
                    HOLD: begin
                        if (cnt == LAST_CNT) begin
                            cnt <= '0;
                            if (last_entry) begin
                                octave <= '0;
                                note   <= '0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                {octave, note} <= rd_data;
                                idx            <= idx + 8'd1;
                            end
                        end else begin
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end
                            if (cnt == PREFETCH_CNT && !last_entry) begin
                                rd_en   <= 1'b1;
                                rd_addr <= idx + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_playback_sequencer
// Description : Scoreboard bench for playback_sequencer with NOTE_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playback_sequencer;

    localparam int NC = 8;
    localparam logic [1:0] K_RD = 2'd0, K_OUT = 2'd1, K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] rec_len = 8'd0;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [5:0] rd_data = 6'd0;
    logic [2:0] octave;
    logic [2:0] note;
    logic       busy;
    logic       done;

    logic [5:0] mem [256];
    ev_t        q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] prev = 8'd0;

    playback_sequencer #(.NOTE_CYCLES(NC), .CNT_W(18)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .rec_len(rec_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .octave(octave), .note(note), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    function automatic string kname(input logic [1:0] k);
        return (k == K_RD) ? "rd" : (k == K_OUT) ? "out" : "done";
    endfunction

    task automatic push(input logic [1:0] k, input int c, input logic [7:0] v);
        q.push_back('{kind: k, cyc: c, val: v});
    endtask

    task automatic observe(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got cycle %0d value %0h, required no event", kname(k), cyc, v);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                errors++;
                $display("FAIL event_%s: got %s cycle %0d value %0h, required %s cycle %0d value %0h",
                         kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: rd strobes, changes of {busy,octave,note}, done pulses.
    always @(negedge clk) begin
        logic [7:0] cur;
        cur = {1'b0, busy, octave, note};
        if (rst) begin
            prev = cur;
        end else begin
            if (rd_en) observe(K_RD, rd_addr);
            if (cur != prev) observe(K_OUT, cur);
            if (done) observe(K_DONE, 8'd0);
            prev = cur;
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_play(input logic [7:0] len, output int s);
        @(negedge clk);
        rec_len = len;
        start   = 1'b1;
        s       = cyc;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] ov(input logic b, input logic [5:0] d);
        return {1'b0, b, d};
    endfunction

    initial begin
        int s;
        for (int i = 0; i < 256; i++) mem[i] = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_note", {octave, note}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic three-entry playback, with an ignored re-edge and rec_len change
        mem[0] = 6'o41; mem[1] = 6'o43; mem[2] = 6'o45;
        start_play(8'd3, s);
        push(K_RD, s+1, 8'd0);  push(K_OUT, s+1, ov(1'b1, 6'o00));
        push(K_OUT, s+3, ov(1'b1, 6'o41));
        push(K_RD, s+9, 8'd1);  push(K_OUT, s+11, ov(1'b1, 6'o43));
        push(K_RD, s+17, 8'd2); push(K_OUT, s+19, ov(1'b1, 6'o45));
        push(K_OUT, s+27, ov(1'b0, 6'o00)); push(K_DONE, s+27, 8'd0);
        @(negedge clk); start = 1'b0;
        go_to(s+5); start = 1'b1; rec_len = 8'd1;
        go_to(s+6); start = 1'b0;
        drain("basic");

        // Zero-length recording
        start_play(8'd0, s);
        push(K_DONE, s+1, 8'd0);
        @(negedge clk); start = 1'b0;
        drain("zero_len");

        // Stop at cycle 12
        start_play(8'd3, s);
        push(K_RD, s+1, 8'd0);  push(K_OUT, s+1, ov(1'b1, 6'o00));
        push(K_OUT, s+3, ov(1'b1, 6'o41));
        push(K_RD, s+9, 8'd1);  push(K_OUT, s+11, ov(1'b1, 6'o43));
        push(K_OUT, s+13, ov(1'b0, 6'o00));
        @(negedge clk); start = 1'b0;
        go_to(s+12); stop = 1'b1;
        go_to(s+13); stop = 1'b0;
        drain("stop");
        repeat (20) @(negedge clk);

        // Rest entry
        mem[1] = 6'o40;
        start_play(8'd3, s);
        push(K_RD, s+1, 8'd0);  push(K_OUT, s+1, ov(1'b1, 6'o00));
        push(K_OUT, s+3, ov(1'b1, 6'o41));
        push(K_RD, s+9, 8'd1);  push(K_OUT, s+11, ov(1'b1, 6'o40));
        push(K_RD, s+17, 8'd2); push(K_OUT, s+19, ov(1'b1, 6'o45));
        push(K_OUT, s+27, ov(1'b0, 6'o00)); push(K_DONE, s+27, 8'd0);
        @(negedge clk); start = 1'b0;
        go_to(s+15); chk("rest_octave", octave, 4); chk("rest_note", note, 0);
        drain("rest");

        // Stop and start edge together: nothing starts
        @(negedge clk); rec_len = 8'd3; start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (12) @(negedge clk);
        chk("stop_wins_busy", busy, 0);

        // Asynchronous reset mid-playback, start held high through release
        mem[1] = 6'o43;
        start_play(8'd3, s);
        push(K_RD, s+1, 8'd0);  push(K_OUT, s+1, ov(1'b1, 6'o00));
        push(K_OUT, s+3, ov(1'b1, 6'o41));
        push(K_RD, s+9, 8'd1);  push(K_OUT, s+11, ov(1'b1, 6'o43));
        go_to(s+14);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_note", {octave, note}, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rd_en", rd_en, 0);
        chk("async_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_start_busy", busy, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start_play(8'd1, s);
        push(K_RD, s+1, 8'd0);  push(K_OUT, s+1, ov(1'b1, 6'o00));
        push(K_OUT, s+3, ov(1'b1, 6'o41));
        push(K_OUT, s+11, ov(1'b0, 6'o00)); push(K_DONE, s+11, 8'd0);
        @(negedge clk); start = 1'b0;
        drain("after_reset");

        // Full 255-entry recording
        for (int i = 0; i < 256; i++) mem[i] = 6'((i % 63) + 1);
        start_play(8'd255, s);
        for (int k = 0; k < 255; k++) begin
            push(K_RD, s+1+NC*k, 8'(k));
            if (k == 0) push(K_OUT, s+1, ov(1'b1, 6'o00));
            push(K_OUT, s+3+NC*k, ov(1'b1, mem[k]));
        end
        push(K_OUT, s+3+NC*255, ov(1'b0, 6'o00)); push(K_DONE, s+3+NC*255, 8'd0);
        @(negedge clk); start = 1'b0;
        drain("len255");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
